tgmux_word_sequencer: RTL and testbench



---
 rtl/tgmux_word_sequencer_pkg.sv | 6 +
 rtl/tgmux_word_sequencer_if.sv | 24 ++
 rtl/tgmux_word_sequencer_down_cnt.sv | 15 +
 rtl/tgmux_word_sequencer.sv | 98 +++++++++
 tb/tb_tgmux_word_sequencer.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/tgmux_word_sequencer_pkg.sv
// tgmux_word_sequencer_pkg: shared state encoding and default widths for the word sequencer
package tgmux_word_sequencer_pkg;
    localparam int W_DEF  = 8;
    localparam int CW_DEF = 4;
    typedef enum logic [1:0] {IDLE, SETTLE, PHASE} state_t;
endpackage

// File: rtl/tgmux_word_sequencer_if.sv
// tgmux_word_sequencer_if: upstream handshake plus mux-side outputs of the word sequencer
interface tgmux_word_sequencer_if #(parameter int W = 8, parameter int CW = 4);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [CW-1:0] dwell;
    logic [CW-1:0] nrep;
    logic          abort;
    logic [W-1:0]  word_a;
    logic [W-1:0]  word_b;
    logic          sel;
    logic          out_valid;
    logic          busy;
    logic          done;
    modport master (
        output in_valid, in_a, in_b, dwell, nrep, abort,
        input  in_ready, word_a, word_b, sel, out_valid, busy, done
    );
    modport slave (
        input  in_valid, in_a, in_b, dwell, nrep, abort,
        output in_ready, word_a, word_b, sel, out_valid, busy, done
    );
endinterface

// File: rtl/tgmux_word_sequencer_down_cnt.sv
// tgseq_down_cnt: loadable down-counter that parks at zero and flags it
module tgseq_down_cnt #(parameter int CW = 4) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    output logic          zero
);
    logic [CW-1:0] cnt;
    assign zero = cnt == '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (ld) cnt <= ld_val;
        else if (!zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/tgmux_word_sequencer.sv
// tgmux_word_sequencer: holds an A/B word pair and alternates the mux select with settle gaps and dwell phases
module tgmux_word_sequencer
    import tgmux_word_sequencer_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int CW         = CW_DEF,
    parameter int SETTLE_CYC = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    tgmux_word_sequencer_if.slave bus
);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    state_t        state, state_d;
    logic [W-1:0]  word_a, word_b;
    logic [CW-1:0] dwell_q, nrep_q, rep, rep_d, ld_val;
    logic          sel, sel_d, done, done_d, accept, ld, zero;

    tgseq_down_cnt #(.CW(CW)) u_cnt (.clk(clk), .rst_n(rst_n), .ld(ld), .ld_val(ld_val), .zero(zero));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= 1'b0;
            done    <= 1'b0;
            rep     <= '0;
            word_a  <= '0;
            word_b  <= '0;
            dwell_q <= '0;
            nrep_q  <= '0;
        end else begin
            state <= state_d;
            sel   <= sel_d;
            done  <= done_d;
            rep   <= rep_d;
            if (accept) begin
                word_a  <= bus.in_a;
                word_b  <= bus.in_b;
                dwell_q <= (bus.dwell == '0) ? CW'(1) : bus.dwell;
                nrep_q  <= (bus.nrep == '0) ? CW'(1) : bus.nrep;
            end
        end

    // counter reloads on every state entry; it holds remaining cycles minus one
    always_comb begin
        state_d = state;
        sel_d   = sel;
        rep_d   = rep;
        done_d  = 1'b0;
        accept  = 1'b0;
        ld      = 1'b0;
        ld_val  = SETTLE_LD;
        case (state)
            IDLE: if (bus.in_valid) begin
                accept  = 1'b1;
                ld      = 1'b1;
                sel_d   = 1'b0;
                rep_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: if (zero) begin
                ld      = 1'b1;
                ld_val  = dwell_q - 1'b1;
                state_d = PHASE;
            end
            PHASE: if (zero) begin
                ld = 1'b1;
                if (!sel) begin
                    sel_d   = 1'b1;
                    state_d = SETTLE;
                end else if (rep + 1'b1 < nrep_q) begin
                    rep_d   = rep + 1'b1;
                    sel_d   = 1'b0;
                    state_d = SETTLE;
                end else begin
                    sel_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // abort overrides everything, including a completion on the same edge
        if (bus.abort && state != IDLE) begin
            state_d = IDLE;
            sel_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.busy      = state != IDLE;
    assign bus.out_valid = state == PHASE;
    assign bus.sel       = sel;
    assign bus.done      = done;
    assign bus.word_a    = word_a;
    assign bus.word_b    = word_b;
endmodule

// File: tb/tb_tgmux_word_sequencer.sv
// tb_tgmux_word_sequencer: directed sequences with a timed scoreboard of valid and done cycles
module tb_tgmux_word_sequencer;
    localparam int S = 1;
    typedef struct {
        logic       dn;
        logic       sel;
        logic [7:0] a;
        logic [7:0] b;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t me;

    tgmux_word_sequencer_if bus();
    tgmux_word_sequencer #(.SETTLE_CYC(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (rst_n && (bus.out_valid || bus.done)) begin
            if (q.size() == 0) chk("unexpected_output", {62'd0, bus.done, bus.out_valid}, 64'd0);
            else begin
                me = q.pop_front();
                chk("kind", {62'd0, bus.done, bus.out_valid}, {62'd0, me.dn, !me.dn});
                chk("cycle", 64'(cyc), 64'(me.cyc));
                chk("sel_words", {47'd0, bus.sel, bus.word_a, bus.word_b}, {47'd0, me.sel, me.a, me.b});
                if (me.dn) chk("ready_at_done", 64'(bus.in_ready), 64'd1);
            end
        end

    // offers a pair, waits for acceptance and queues the expected valid/done stream
    task automatic send(input logic [7:0] a, b, input logic [3:0] d, n, input bit keep, input int lim);
        int acc, dq, nq, k;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        bus.dwell = d;
        bus.nrep = n;
        for (int i = 0; i < 200 && !bus.in_ready; i++) @(negedge clk);
        chk("accept_timeout", 64'(bus.in_ready), 64'd1);
        acc = cyc + 1;
        dq = (d == 0) ? 1 : int'(d);
        nq = (n == 0) ? 1 : int'(n);
        k = 0;
        for (int r = 0; r < nq; r++)
            for (int p = 0; p < 2; p++)
                for (int i = 0; i < dq; i++) begin
                    if (lim < 0 || k < lim) q.push_back('{1'b0, p[0], a, b, acc + (2 * r + p) * (S + dq) + S + i});
                    k++;
                end
        if (lim < 0) q.push_back('{1'b1, 1'b0, a, b, acc + nq * 2 * (S + dq)});
        @(negedge clk);
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && bus.busy; i++) @(negedge clk);
        chk("idle_timeout", 64'(bus.busy), 64'd0);
        @(negedge clk);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_outs"}, {40'd0, bus.word_a, bus.word_b, bus.sel, bus.out_valid, bus.busy, bus.done, bus.in_ready},
            {40'd0, 8'h00, 8'h00, 5'b00001});
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.dwell = '0;
        bus.nrep = '0;
        bus.abort = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outs("por");
        rst_n = 1'b1;
        @(negedge clk);
        // basic: 16 cycles accept-to-done
        send(8'hA5, 8'h3C, 4'd3, 4'd2, 1'b0, -1);
        wait_idle();
        chk("words_held", {48'd0, bus.word_a, bus.word_b}, {48'd0, 16'hA53C});
        // zero config behaves as 1/1
        send(8'h11, 8'h22, 4'd0, 4'd0, 1'b0, -1);
        wait_idle();
        // abort on first sel=1 valid cycle
        send(8'h5A, 8'hC3, 4'd2, 4'd3, 1'b0, 3);
        for (int i = 0; i < 100 && !(bus.out_valid && bus.sel); i++) @(negedge clk);
        chk("abort_reach", {62'd0, bus.out_valid, bus.sel}, 64'd3);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_state", {45'd0, bus.word_a, bus.word_b, bus.sel, bus.out_valid, bus.busy, bus.done, bus.in_ready},
            {45'd0, 8'h5A, 8'hC3, 5'b00001});
        repeat (3) @(negedge clk);
        // abort in IDLE must be ignored
        bus.abort = 1'b1;
        send(8'h01, 8'h02, 4'd1, 4'd1, 1'b0, -1);
        bus.abort = 1'b0;
        chk("idle_abort_ignored", 64'(bus.busy), 64'd1);
        wait_idle();
        // back-to-back with in_valid held across done
        send(8'hB1, 8'hB2, 4'd1, 4'd1, 1'b1, -1);
        send(8'hC1, 8'hC2, 4'd2, 4'd1, 1'b0, -1);
        wait_idle();
        // new pair offered while busy is ignored
        send(8'h77, 8'h88, 4'd2, 4'd2, 1'b0, -1);
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a = 8'hFF;
        bus.in_b = 8'hEE;
        chk("busy_ready_lo0", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("busy_ready_lo1", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        wait_idle();
        chk("queue_drained", 64'(q.size()), 64'd0);
        // reset mid-PHASE
        send(8'h99, 8'h66, 4'd3, 4'd1, 1'b0, -1);
        for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
        chk("phase_reach", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("mid_reset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk_reset_outs("post_reset");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
